// File: rtl/datapath_seq.sv
// -----------------------------------------------------------------------------
// datapath_seq
//
// Multi-cycle sequencer for the 4-register / ALU32 datapath. It takes one
// micro-instruction at a time over a valid/ready handshake. It then drives the
// datapath control inputs (wr, ALUControl, addr1/2/3) to run the same register
// operation instr_rep+1 times. Each iteration lasts two cycles:
//   SETUP : wr=0, the register-file read and the ALU settle on the current
//           register contents.
//   WRITE : wr=1, the register file captures Result at the closing edge.
// A command ends early when Overflow is seen and OVF_HALT is set, or when
// Zero is seen and the command asked for stop-on-zero.
//
// Parameters
//   REP_W    : width of the repeat field; up to 2^REP_W iterations per command
//   OVF_HALT : 1 = abort on the first overflowing write, 0 = only record it
//
// Ports
//   clk, rst                 : rising-edge clock, async active-high reset
//   instr_valid/instr_ready  : command handshake (ready only in IDLE)
//   instr_op                 : ALUControl value for the command
//   instr_rd/rs1/rs2         : destination / source A / source B registers
//   instr_rep                : iteration count minus one
//   instr_stopz              : end the command on a write with Zero=1
//   wr, ALUControl,
//   addr1, addr2, addr3      : registered control outputs to the datapath
//   Zero, Overflow           : status inputs from the datapath ALU
//   busy                     : command in progress (SETUP or WRITE)
//   done                     : one-cycle pulse when a command finishes
//   iter_count               : writes completed by the last/current command
//   ovf_flag                 : an overflowing write occurred in the command
//   zero_flag                : Zero value captured on the final write
// -----------------------------------------------------------------------------
module datapath_seq #(
  parameter int REP_W    = 3,
  parameter int OVF_HALT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [2:0]       instr_op,
  input  logic [1:0]       instr_rd,
  input  logic [1:0]       instr_rs1,
  input  logic [1:0]       instr_rs2,
  input  logic [REP_W-1:0] instr_rep,
  input  logic             instr_stopz,
  output logic             instr_ready,
  output logic             wr,
  output logic [2:0]       ALUControl,
  output logic [1:0]       addr1,
  output logic [1:0]       addr2,
  output logic [1:0]       addr3,
  input  logic             Zero,
  input  logic             Overflow,
  output logic             busy,
  output logic             done,
  output logic [REP_W:0]   iter_count,
  output logic             ovf_flag,
  output logic             zero_flag
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam bit             OVF_HALT_EN = (OVF_HALT != 0);
  localparam logic [REP_W:0] ITER_ONE    = 1;
  localparam logic [REP_W-1:0] REM_ONE   = 1;

  state_t           state;
  state_t           state_nxt;
  logic [REP_W-1:0] remaining;
  logic             stopz_q;
  logic             end_cmd;

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state == S_SETUP) || (state == S_WRITE);

  // Termination test for the write in progress. Only WRITE looks at it, so
  // Zero/Overflow are only sampled on the edge that commits a result.
  assign end_cmd = (OVF_HALT_EN && Overflow) ||
                   (stopz_q && Zero)         ||
                   (remaining == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (instr_valid) state_nxt = S_SETUP;
      S_SETUP: state_nxt = S_WRITE;
      S_WRITE: state_nxt = end_cmd ? S_DONE : S_SETUP;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // wr and done are registered from the next state, so they are high exactly
  // during WRITE and DONE. An async reset drops wr at once, so the write that
  // is being set up never reaches the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr         <= 1'b0;
      done       <= 1'b0;
      ALUControl <= 3'b000;
      addr1      <= 2'b00;
      addr2      <= 2'b00;
      addr3      <= 2'b00;
      stopz_q    <= 1'b0;
      remaining  <= '0;
      iter_count <= '0;
      ovf_flag   <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      wr   <= (state_nxt == S_WRITE);
      done <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ALUControl <= instr_op;
            addr1      <= instr_rs1;
            addr2      <= instr_rs2;
            addr3      <= instr_rd;
            stopz_q    <= instr_stopz;
            remaining  <= instr_rep;
            iter_count <= '0;
            ovf_flag   <= 1'b0;
          end
        end
        S_WRITE: begin
          iter_count <= iter_count + ITER_ONE;
          zero_flag  <= Zero;
          ovf_flag   <= ovf_flag | Overflow;
          if (!end_cmd) remaining <= remaining - REM_ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// -----------------------------------------------------------------------------
// tb_datapath_seq
//
// Directed bench for datapath_seq. Two sequencers are instantiated: u_dut_a
// with OVF_HALT=1 and u_dut_b with OVF_HALT=0. Each one drives its own
// behavioural 4x32 register file + ALU (000 add, 001 sub, 010 and, 011 or).
// Expected values are hand-computed constants for each scenario.
// -----------------------------------------------------------------------------
module tb_datapath_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       valid_a, valid_b;
  logic [2:0] op;
  logic [1:0] rd, rs1, rs2;
  logic [2:0] rep;
  logic       stopz;

  logic       ready_a, wr_a, busy_a, done_a, ovf_a, zf_a, zero_a, ovfin_a;
  logic [2:0] alu_a;
  logic [1:0] a1_a, a2_a, a3_a;
  logic [3:0] iter_a;
  logic       ready_b, wr_b, busy_b, done_b, ovf_b, zf_b, zero_b, ovfin_b;
  logic [2:0] alu_b;
  logic [1:0] a1_b, a2_b, a3_b;
  logic [3:0] iter_b;

  logic [31:0] rf_a [4];
  logic [31:0] rf_b [4];
  logic [31:0] res_a, res_b;

  datapath_seq #(.REP_W(3), .OVF_HALT(1)) u_dut_a (
    .clk(clk), .rst(rst), .instr_valid(valid_a), .instr_op(op),
    .instr_rd(rd), .instr_rs1(rs1), .instr_rs2(rs2), .instr_rep(rep),
    .instr_stopz(stopz), .instr_ready(ready_a), .wr(wr_a),
    .ALUControl(alu_a), .addr1(a1_a), .addr2(a2_a), .addr3(a3_a),
    .Zero(zero_a), .Overflow(ovfin_a), .busy(busy_a), .done(done_a),
    .iter_count(iter_a), .ovf_flag(ovf_a), .zero_flag(zf_a)
  );

  datapath_seq #(.REP_W(3), .OVF_HALT(0)) u_dut_b (
    .clk(clk), .rst(rst), .instr_valid(valid_b), .instr_op(op),
    .instr_rd(rd), .instr_rs1(rs1), .instr_rs2(rs2), .instr_rep(rep),
    .instr_stopz(stopz), .instr_ready(ready_b), .wr(wr_b),
    .ALUControl(alu_b), .addr1(a1_b), .addr2(a2_b), .addr3(a3_b),
    .Zero(zero_b), .Overflow(ovfin_b), .busy(busy_b), .done(done_b),
    .iter_count(iter_b), .ovf_flag(ovf_b), .zero_flag(zf_b)
  );

  // Datapath model: {Overflow, Zero, Result}
  function automatic logic [33:0] alu_fn(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (f)
      3'b000: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b001: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      default: r = '0;
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  always_comb begin
    {ovfin_a, zero_a, res_a} = alu_fn(alu_a, rf_a[a1_a], rf_a[a2_a]);
    {ovfin_b, zero_b, res_b} = alu_fn(alu_b, rf_b[a1_b], rf_b[a2_b]);
  end

  logic        pl_en = 1'b0;
  logic [1:0]  pl_idx = 2'd0;
  logic [31:0] pl_val = 32'd0;

  always @(posedge clk) begin
    if (pl_en) begin
      rf_a[pl_idx] <= pl_val;
      rf_b[pl_idx] <= pl_val;
    end else begin
      if (wr_a) rf_a[a3_a] <= res_a;
      if (wr_b) rf_b[a3_b] <= res_b;
    end
  end

  // Event monitors: cycle index = number of rising edges seen so far.
  int   cyc = 0;
  int   acc_cnt_a = 0, acc_cyc_a = 0;
  int   wr_cnt_a = 0, wr_cnt_b = 0, b2b_a = 0;
  int   done_cnt_a = 0, done_cyc_a = 0;
  int   wr_cyc_a [16];
  logic prev_wr_a = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (valid_a && ready_a) begin
      acc_cnt_a <= acc_cnt_a + 1;
      acc_cyc_a <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (wr_a) begin
      wr_cyc_a[wr_cnt_a % 16] <= cyc;
      wr_cnt_a <= wr_cnt_a + 1;
      if (prev_wr_a) b2b_a <= b2b_a + 1;
    end
    prev_wr_a <= wr_a;
    if (wr_b) wr_cnt_b <= wr_cnt_b + 1;
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      done_cyc_a <= cyc;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic preload(input logic [1:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // Present a command on sequencer a (sel=0) or b (sel=1), hold valid until
  // it is accepted. acc = index of the accepting edge.
  task automatic send(input bit sel, input logic [2:0] f, input logic [1:0] d,
                      input logic [1:0] s1, input logic [1:0] s2,
                      input logic [2:0] n, input logic sz, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = 0;
    op = f; rd = d; rs1 = s1; rs2 = s2; rep = n; stopz = sz;
    if (sel) valid_b = 1'b1;
    else     valid_a = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (sel ? ready_b : ready_a) begin
        @(negedge clk);
        acc = cyc;
        ok  = 1'b1;
        break;
      end
      @(negedge clk);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input bit sel, output int ready_hi, output int dcyc);
    bit got;
    got      = 1'b0;
    ready_hi = 0;
    dcyc     = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sel ? done_b : done_a) begin
        got  = 1'b1;
        dcyc = cyc;
        break;
      end
      if (sel ? ready_b : ready_a) ready_hi++;
    end
    #1;
    chk("done_timeout", 32'(got), 32'd1);
  endtask

  int acc, acc2, dcyc, rhi, wbase, wbase_b, dbase, abase, d1;

  initial begin
    valid_a = 1'b0; valid_b = 1'b0;
    op = 3'd0; rd = 2'd0; rs1 = 2'd0; rs2 = 2'd0; rep = 3'd0; stopz = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_wr",    32'(wr_a),    32'd0);
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_iter",  32'(iter_a),  32'd0);
    chk("rst_ovf",   32'(ovf_a),   32'd0);
    chk("rst_zf",    32'(zf_a),    32'd0);
    chk("rst_alu",   32'(alu_a),   32'd0);
    chk("rst_addr3", 32'(a3_a),    32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) preload(2'(i), 32'd0);

    // Single add: R3 <- R0 + R3 once
    preload(2'd0, 32'd1);
    preload(2'd3, 32'd0);
    wbase = wr_cnt_a;
    send(1'b0, 3'b000, 2'd3, 2'd0, 2'd3, 3'd0, 1'b0, acc);
    chk("t2_busy", 32'(busy_a), 32'd1);
    wait_done(1'b0, rhi, dcyc);
    chk("t2_wr_cnt",   32'(wr_cnt_a - wbase),       32'd1);
    chk("t2_wr_cyc",   32'(wr_cyc_a[wbase % 16] - acc), 32'd1);
    chk("t2_done_cyc", 32'(dcyc - acc),             32'd2);
    chk("t2_r3",       rf_a[3],                     32'd1);
    chk("t2_iter",     32'(iter_a),                 32'd1);
    chk("t2_zf",       32'(zf_a),                   32'd0);
    chk("t2_ready_in_done", 32'(ready_a),           32'd0);
    @(negedge clk);
    chk("t2_done_pulse", 32'(done_a), 32'd0);

    // Repeat accumulate: 5 iterations
    preload(2'd0, 32'd1);
    preload(2'd3, 32'd0);
    wbase = wr_cnt_a;
    send(1'b0, 3'b000, 2'd3, 2'd0, 2'd3, 3'd4, 1'b0, acc);
    wait_done(1'b0, rhi, dcyc);
    chk("t3_wr_cnt", 32'(wr_cnt_a - wbase), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("t3_wr_cyc", 32'(wr_cyc_a[(wbase + i) % 16] - acc), 32'(1 + 2 * i));
    chk("t3_done_cyc", 32'(dcyc - acc), 32'd10);
    chk("t3_r3",       rf_a[3],         32'd5);
    chk("t3_iter",     32'(iter_a),     32'd5);
    chk("t3_ready_lo", 32'(rhi),        32'd0);
    chk("t3_b2b",      32'(b2b_a),      32'd0);

    // Stop on zero: 3 + 3*(-1) reaches 0 on the third write
    preload(2'd0, 32'hFFFF_FFFF);
    preload(2'd3, 32'd3);
    wbase = wr_cnt_a;
    send(1'b0, 3'b000, 2'd3, 2'd0, 2'd3, 3'd7, 1'b1, acc);
    wait_done(1'b0, rhi, dcyc);
    chk("t4_wr_cnt", 32'(wr_cnt_a - wbase), 32'd3);
    chk("t4_r3",     rf_a[3],               32'd0);
    chk("t4_iter",   32'(iter_a),           32'd3);
    chk("t4_zf",     32'(zf_a),             32'd1);
    chk("t4_ovf",    32'(ovf_a),            32'd0);

    // Overflow halt on a, record-only on b
    preload(2'd0, 32'h4000_0000);
    preload(2'd3, 32'h4000_0000);
    send(1'b0, 3'b000, 2'd3, 2'd0, 2'd3, 3'd3, 1'b0, acc);
    wait_done(1'b0, rhi, dcyc);
    chk("t5a_iter",     32'(iter_a),    32'd1);
    chk("t5a_ovf",      32'(ovf_a),     32'd1);
    chk("t5a_r3",       rf_a[3],        32'h8000_0000);
    chk("t5a_done_cyc", 32'(dcyc - acc), 32'd2);
    wbase_b = wr_cnt_b;
    send(1'b1, 3'b000, 2'd3, 2'd0, 2'd3, 3'd3, 1'b0, acc);
    wait_done(1'b1, rhi, dcyc);
    chk("t5b_iter",   32'(iter_b),            32'd4);
    chk("t5b_ovf",    32'(ovf_b),             32'd1);
    chk("t5b_zf",     32'(zf_b),              32'd0);
    chk("t5b_r3",     rf_b[3],                32'h4000_0000);
    chk("t5b_wr_cnt", 32'(wr_cnt_b - wbase_b), 32'd4);

    // New command clears ovf_flag on accept
    send(1'b0, 3'b010, 2'd1, 2'd0, 2'd0, 3'd0, 1'b0, acc);
    chk("t5_ovf_clr", 32'(ovf_a), 32'd0);
    wait_done(1'b0, rhi, dcyc);

    // Handshake: valid held high across a running command
    preload(2'd0, 32'd1);
    preload(2'd3, 32'd0);
    preload(2'd2, 32'd0);
    abase = acc_cnt_a;
    dbase = done_cnt_a;
    send(1'b0, 3'b000, 2'd3, 2'd0, 2'd3, 3'd1, 1'b0, acc);
    send(1'b0, 3'b000, 2'd2, 2'd3, 2'd3, 3'd0, 1'b0, acc2);
    d1 = done_cyc_a;
    chk("t6_acc_after_done", 32'(acc2 - d1), 32'd2);
    wait_done(1'b0, rhi, dcyc);
    chk("t6_acc_cnt",  32'(acc_cnt_a - abase),  32'd2);
    chk("t6_done_cnt", 32'(done_cnt_a - dbase), 32'd2);
    chk("t6_r3",       rf_a[3],                 32'd2);
    chk("t6_r2",       rf_a[2],                 32'd4);
    chk("t6_iter",     32'(iter_a),             32'd1);

    // Reset mid-WRITE on the second write of a 4-iteration accumulate
    preload(2'd0, 32'd1);
    preload(2'd3, 32'd0);
    wbase = wr_cnt_a;
    dbase = done_cnt_a;
    send(1'b0, 3'b000, 2'd3, 2'd0, 2'd3, 3'd3, 1'b0, acc);
    begin
      int  seen;
      bit  hit;
      seen = 0;
      hit  = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (wr_a) begin
          seen++;
          if (seen == 2) begin
            hit = 1'b1;
            break;
          end
        end
        @(negedge clk);
      end
      chk("t1_reach_write", 32'(hit), 32'd1);
    end
    #1 rst = 1'b1;
    #1;
    chk("t1_wr",    32'(wr_a),    32'd0);
    chk("t1_ready", 32'(ready_a), 32'd1);
    chk("t1_iter",  32'(iter_a),  32'd0);
    chk("t1_busy",  32'(busy_a),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("t1_no_done", 32'(done_cnt_a - dbase), 32'd0);
    chk("t1_wr_cnt",  32'(wr_cnt_a - wbase),   32'd2);
    chk("t1_r3",      rf_a[3],                 32'd1);
    chk("t1_ready2",  32'(ready_a),            32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Multi-cycle sequencer for the 4-register / ALU32 datapath (ports clk, rst, wr, ALUControl, addr1, addr2, addr3, Result, Zero, Overflow).
- Accepts one micro-instruction at a time over a valid/ready handshake, then drives the datapath's control inputs.
- Can repeat the same register operation N+1 times, e.g. accumulate R3 <- R0 + R3. Early termination on Zero or Overflow.
- Sits between a test or host stimulus source and the datapath.

Parameters:
- REP_W, 3: width of the repeat field; a command runs up to 2^REP_W iterations.
- OVF_HALT, 1: 1 = abort the command on the first iteration whose Overflow=1; 0 = only record it.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-high reset.
- instr_valid, in, 1: command present.
- instr_op, in, 3: ALUControl value to apply.
- instr_rd, in, 2: destination register (to addr3).
- instr_rs1, in, 2: source A (to addr1).
- instr_rs2, in, 2: source B (to addr2).
- instr_rep, in, REP_W: iteration count minus 1.
- instr_stopz, in, 1: terminate early when Zero=1 on a write.
- instr_ready, out, 1: sequencer can accept a command.
- wr, out, 1: register-file write enable to the datapath.
- ALUControl, out, 3: to datapath.
- addr1, out, 2: to datapath.
- addr2, out, 2: to datapath.
- addr3, out, 2: to datapath.
- Zero, in, 1: from datapath.
- Overflow, in, 1: from datapath.
- busy, out, 1: command in progress.
- done, out, 1: one-cycle pulse when a command ends.
- iter_count, out, REP_W+1: writes completed by the last or current command.
- ovf_flag, out, 1: an overflow occurred during the last command.
- zero_flag, out, 1: Zero value on the final write of the last command.

Behaviour:
- States: IDLE, SETUP, WRITE, DONE. State and all outputs are registered except instr_ready and busy, which are decoded from state.
- instr_ready = (state==IDLE). busy = (state==SETUP || state==WRITE).
- Reset (async, rst=1): state IDLE; wr=0; ALUControl=000; addr1/2/3=0; done=0; iter_count=0; ovf_flag=0; zero_flag=0; instr_ready=1.
- IDLE: at a clock edge with instr_valid && instr_ready:
  - latch op, rd, rs1, rs2, stopz;
  - remaining <= instr_rep;
  - drive ALUControl/addr1/addr2/addr3 from the latched fields;
  - clear iter_count and ovf_flag;
  - go to SETUP.
  - instr_valid while not ready is ignored; the source must hold it.
- SETUP: wr=0 for exactly one cycle so the combinational read and ALU settle. Then go to WRITE.
- WRITE: wr=1 for exactly one cycle; the register file writes Result at the edge ending this cycle. At that same edge:
  - sample Zero and Overflow;
  - iter_count += 1;
  - zero_flag <= Zero;
  - ovf_flag |= Overflow;
  - wr <= 0.
- WRITE next state, in priority order:
  - (OVF_HALT && Overflow) -> DONE;
  - (stopz && Zero) -> DONE;
  - remaining==0 -> DONE;
  - otherwise remaining -= 1 and go to SETUP.
- Per-iteration latency is 2 cycles. A command with rep=N takes 2(N+1) cycles from the accept edge to entering DONE.
- DONE: done=1 for one cycle, instr_ready=0. Next state IDLE. Control addresses and op hold their last values; wr stays 0.
- wr is never asserted outside WRITE. There is never more than one write per iteration and no back-to-back writes.
- The rd==rs1 or rd==rs2 hazard is resolved by the SETUP cycle, because each iteration reads the value written by the previous one.
- rst mid-command:
  - returns to IDLE immediately, deasserts wr asynchronously, and clears the flags;
  - no done pulse;
  - a write partially set up is discarded.
- iter_count width REP_W+1 holds the maximum 2^REP_W without wrap.

Test Plan:
1. Reset: assert rst mid-WRITE (wr=1). Required: wr drops to 0 immediately, instr_ready=1, iter_count=0, no done pulse.
2. Single add:
   - preload R0=1, R3=0;
   - command op=000, rs1=0, rs2=3, rd=3, rep=0;
   - required: wr high for exactly 1 cycle, 2 cycles after accept;
   - done pulse follows; R3=1; iter_count=1; zero_flag=0.
3. Repeat accumulate: R0=1, R3=0, rep=4. Required:
   - 5 wr pulses spaced 2 cycles apart;
   - R3=5, iter_count=5, done 10 cycles after accept;
   - instr_ready=0 throughout.
4. Stop on zero:
   - R0=0xFFFFFFFF, R3=3, add with rd=3, rep=7, stopz=1;
   - required: termination after 3 writes (R3=0), iter_count=3, zero_flag=1.
5. Overflow halt (OVF_HALT=1):
   - R0=R3=0x40000000, add with rd=3, rep=3;
   - required: first write 0x80000000 with Overflow=1, abort, iter_count=1, ovf_flag=1.
   - With OVF_HALT=0: iter_count=4, ovf_flag=1.
6. Handshake: hold instr_valid high across a running command. Required:
   - the second command is accepted only on the edge after DONE, i.e. while in IDLE;
   - no command is lost or duplicated.
